// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM register, the data memory and the MEM/WB register,
// as seen by the memory-access stage.
interface mem_stage_if;
  logic       EX_Valid;
  logic [1:0] EX_Op;
  logic [7:0] EX_Result;
  logic [7:0] EX_Data;
  logic [2:0] EX_Rd;
  logic       EX_Reg_W;
  logic       Mem_Stall;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data_in;
  logic       Mem_W_En;
  logic       Mem_R_En;
  logic [7:0] Mem_Data_out;
  logic       WB_Valid;
  logic [7:0] WB_Data;
  logic [2:0] WB_Rd;
  logic       WB_Reg_W;

  modport slave (
    input  EX_Valid, EX_Op, EX_Result, EX_Data, EX_Rd, EX_Reg_W, Mem_Data_out,
    output Mem_Stall, Mem_Address, Mem_Data_in, Mem_W_En, Mem_R_En,
           WB_Valid, WB_Data, WB_Rd, WB_Reg_W
  );

  modport master (
    output EX_Valid, EX_Op, EX_Result, EX_Data, EX_Rd, EX_Reg_W, Mem_Data_out,
    input  Mem_Stall, Mem_Address, Mem_Data_in, Mem_W_En, Mem_R_En,
           WB_Valid, WB_Data, WB_Rd, WB_Reg_W
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit RISC pipeline: drives the data memory, registers the
// MEM/WB result and runs the two-cycle atomic swap (read, stall, then write).
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  mem_stage_if.slave  bus
);

  typedef enum logic {IDLE, SWP_WR} state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;

  state_t     state_q, state_d;
  logic       wb_valid_q, wb_valid_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic [2:0] wb_rd_q, wb_rd_d;
  logic       wb_reg_w_q, wb_reg_w_d;
  logic [7:0] swap_addr_q, swap_addr_d;
  logic [7:0] swap_data_q, swap_data_d;
  logic [7:0] swap_old_q, swap_old_d;
  logic [2:0] swap_rd_q, swap_rd_d;
  logic       swap_reg_w_q, swap_reg_w_d;

  logic       mem_r_en, mem_w_en, mem_stall;
  logic [7:0] mem_addr, mem_din;

  always_comb begin
    state_d      = state_q;
    wb_valid_d   = 1'b0;
    wb_reg_w_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    swap_addr_d  = swap_addr_q;
    swap_data_d  = swap_data_q;
    swap_old_d   = swap_old_q;
    swap_rd_d    = swap_rd_q;
    swap_reg_w_d = swap_reg_w_q;
    mem_r_en     = 1'b0;
    mem_w_en     = 1'b0;
    mem_stall    = 1'b0;
    mem_addr     = 8'h00;
    mem_din      = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.EX_Valid) begin
          case (bus.EX_Op)
            OP_ALU: begin
              wb_valid_d = 1'b1;
              wb_data_d  = bus.EX_Result;
              wb_rd_d    = bus.EX_Rd;
              wb_reg_w_d = bus.EX_Reg_W;
            end
            OP_LD: begin
              mem_r_en   = 1'b1;
              mem_addr   = bus.EX_Result;
              wb_valid_d = 1'b1;
              wb_data_d  = bus.Mem_Data_out;
              wb_rd_d    = bus.EX_Rd;
              wb_reg_w_d = bus.EX_Reg_W;
            end
            OP_ST: begin
              mem_w_en   = 1'b1;
              mem_addr   = bus.EX_Result;
              mem_din    = bus.EX_Data;
              wb_valid_d = 1'b1;
              wb_data_d  = bus.EX_Data;
              wb_rd_d    = bus.EX_Rd;
            end
            default: begin
              // Swap read phase: capture everything so EX/MEM may change next cycle
              mem_r_en     = 1'b1;
              mem_addr     = bus.EX_Result;
              mem_stall    = 1'b1;
              swap_old_d   = bus.Mem_Data_out;
              swap_addr_d  = bus.EX_Result;
              swap_data_d  = bus.EX_Data;
              swap_rd_d    = bus.EX_Rd;
              swap_reg_w_d = bus.EX_Reg_W;
              state_d      = SWP_WR;
            end
          endcase
        end
      end
      SWP_WR: begin
        mem_w_en   = 1'b1;
        mem_addr   = swap_addr_q;
        mem_din    = swap_data_q;
        wb_valid_d = 1'b1;
        wb_data_d  = swap_old_q;
        wb_rd_d    = swap_rd_q;
        wb_reg_w_d = swap_reg_w_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset blocks the memory combinationally so a pending swap write never lands
    if (RST) begin
      mem_r_en  = 1'b0;
      mem_w_en  = 1'b0;
      mem_stall = 1'b0;
      mem_addr  = 8'h00;
      mem_din   = 8'h00;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 8'h00;
      wb_rd_q      <= 3'd0;
      wb_reg_w_q   <= 1'b0;
      swap_addr_q  <= 8'h00;
      swap_data_q  <= 8'h00;
      swap_old_q   <= 8'h00;
      swap_rd_q    <= 3'd0;
      swap_reg_w_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_reg_w_q   <= wb_reg_w_d;
      swap_addr_q  <= swap_addr_d;
      swap_data_q  <= swap_data_d;
      swap_old_q   <= swap_old_d;
      swap_rd_q    <= swap_rd_d;
      swap_reg_w_q <= swap_reg_w_d;
    end
  end

  assign bus.Mem_R_En    = mem_r_en;
  assign bus.Mem_W_En    = mem_w_en;
  assign bus.Mem_Stall   = mem_stall;
  assign bus.Mem_Address = mem_addr;
  assign bus.Mem_Data_in = mem_din;
  assign bus.WB_Valid    = wb_valid_q;
  assign bus.WB_Data     = wb_data_q;
  assign bus.WB_Rd       = wb_rd_q;
  assign bus.WB_Reg_W    = wb_reg_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a 256-byte behavioural data memory
// (write on the clock edge, asynchronous read returning 0 when R_En is low).
module tb_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] mem [256];
  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  mem_stage_if bus();

  mem_stage dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.Mem_Data_out = bus.Mem_R_En ? mem[bus.Mem_Address] : 8'h00;

  always @(posedge clk) begin
    if (bus.Mem_W_En) mem[bus.Mem_Address] <= bus.Mem_Data_in;
    else if (pre_en)  mem[pre_addr] <= pre_data;
  end

  // Advance one clock; inputs are then changed 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] res,
                       input logic [7:0] dat, input logic [2:0] rd, input logic rw);
    bus.EX_Valid  = v;
    bus.EX_Op     = op;
    bus.EX_Result = res;
    bus.EX_Data   = dat;
    bus.EX_Rd     = rd;
    bus.EX_Reg_W  = rw;
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b10, 8'h44, 8'hA5, 3'd2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.Mem_W_En !== 1'b0 || bus.Mem_R_En !== 1'b0 || bus.Mem_Stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_enables: got W=%b R=%b S=%b, expected 0 0 0",
                 bus.Mem_W_En, bus.Mem_R_En, bus.Mem_Stall);
      end
      tick();
      #1;
    end
    checks++;
    if (bus.WB_Valid !== 1'b0 || bus.WB_Data !== 8'h00 || bus.WB_Rd !== 3'd0 || bus.WB_Reg_W !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb: got V=%b D=%h Rd=%0d RW=%b, expected 0 00 0 0",
               bus.WB_Valid, bus.WB_Data, bus.WB_Rd, bus.WB_Reg_W);
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
  endtask

  task automatic test_store_load();
    drive(1'b1, 2'b10, 8'h10, 8'h5A, 3'd4, 1'b1);
    checks++;
    if (bus.Mem_W_En !== 1'b1 || bus.Mem_R_En !== 1'b0 || bus.Mem_Address !== 8'h10 || bus.Mem_Data_in !== 8'h5A) begin
      errors++;
      $display("FAIL st_bus: got W=%b R=%b A=%h D=%h, expected 1 0 10 5a",
               bus.Mem_W_En, bus.Mem_R_En, bus.Mem_Address, bus.Mem_Data_in);
    end
    tick();
    drive(1'b1, 2'b01, 8'h10, 8'hFF, 3'd3, 1'b1);
    checks++;
    if (bus.WB_Valid !== 1'b1 || bus.WB_Reg_W !== 1'b0 || bus.WB_Data !== 8'h5A) begin
      errors++;
      $display("FAIL st_wb: got V=%b RW=%b D=%h, expected 1 0 5a",
               bus.WB_Valid, bus.WB_Reg_W, bus.WB_Data);
    end
    checks++;
    if (bus.Mem_R_En !== 1'b1 || bus.Mem_W_En !== 1'b0 || bus.Mem_Address !== 8'h10 || bus.Mem_Stall !== 1'b0) begin
      errors++;
      $display("FAIL ld_bus: got R=%b W=%b A=%h S=%b, expected 1 0 10 0",
               bus.Mem_R_En, bus.Mem_W_En, bus.Mem_Address, bus.Mem_Stall);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.WB_Data !== 8'h5A || bus.WB_Rd !== 3'd3 || bus.WB_Reg_W !== 1'b1 || bus.WB_Valid !== 1'b1) begin
      errors++;
      $display("FAIL ld_wb: got D=%h Rd=%0d RW=%b V=%b, expected 5a 3 1 1",
               bus.WB_Data, bus.WB_Rd, bus.WB_Reg_W, bus.WB_Valid);
    end
    tick();
    checks++;
    if (bus.WB_Valid !== 1'b0 || bus.WB_Reg_W !== 1'b0 || bus.WB_Data !== 8'h5A || bus.WB_Rd !== 3'd3) begin
      errors++;
      $display("FAIL bubble_hold: got V=%b RW=%b D=%h Rd=%0d, expected 0 0 5a 3",
               bus.WB_Valid, bus.WB_Reg_W, bus.WB_Data, bus.WB_Rd);
    end
  endtask

  task automatic test_passthrough();
    drive(1'b1, 2'b00, 8'h7F, 8'hC3, 3'd5, 1'b1);
    checks++;
    if (bus.Mem_W_En !== 1'b0 || bus.Mem_R_En !== 1'b0 || bus.Mem_Address !== 8'h00 || bus.Mem_Data_in !== 8'h00) begin
      errors++;
      $display("FAIL alu_bus: got W=%b R=%b A=%h D=%h, expected 0 0 00 00",
               bus.Mem_W_En, bus.Mem_R_En, bus.Mem_Address, bus.Mem_Data_in);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.WB_Data !== 8'h7F || bus.WB_Rd !== 3'd5 || bus.WB_Valid !== 1'b1 || bus.WB_Reg_W !== 1'b1) begin
      errors++;
      $display("FAIL alu_wb: got D=%h Rd=%0d V=%b RW=%b, expected 7f 5 1 1",
               bus.WB_Data, bus.WB_Rd, bus.WB_Valid, bus.WB_Reg_W);
    end
  endtask

  task automatic test_swap();
    preload(8'h20, 8'h11);
    drive(1'b1, 2'b11, 8'h20, 8'h22, 3'd1, 1'b1);
    checks++;
    if (bus.Mem_Stall !== 1'b1 || bus.Mem_R_En !== 1'b1 || bus.Mem_W_En !== 1'b0 || bus.Mem_Address !== 8'h20) begin
      errors++;
      $display("FAIL swp_rd_bus: got S=%b R=%b W=%b A=%h, expected 1 1 0 20",
               bus.Mem_Stall, bus.Mem_R_En, bus.Mem_W_En, bus.Mem_Address);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.WB_Valid !== 1'b0 || bus.WB_Reg_W !== 1'b0) begin
      errors++;
      $display("FAIL swp_bubble: got V=%b RW=%b, expected 0 0", bus.WB_Valid, bus.WB_Reg_W);
    end
    checks++;
    if (bus.Mem_W_En !== 1'b1 || bus.Mem_R_En !== 1'b0 || bus.Mem_Stall !== 1'b0 ||
        bus.Mem_Address !== 8'h20 || bus.Mem_Data_in !== 8'h22) begin
      errors++;
      $display("FAIL swp_wr_bus: got W=%b R=%b S=%b A=%h D=%h, expected 1 0 0 20 22",
               bus.Mem_W_En, bus.Mem_R_En, bus.Mem_Stall, bus.Mem_Address, bus.Mem_Data_in);
    end
    tick();
    drive(1'b1, 2'b01, 8'h20, 8'h00, 3'd6, 1'b1);
    checks++;
    if (bus.WB_Data !== 8'h11 || bus.WB_Rd !== 3'd1 || bus.WB_Valid !== 1'b1 || bus.WB_Reg_W !== 1'b1) begin
      errors++;
      $display("FAIL swp_wb: got D=%h Rd=%0d V=%b RW=%b, expected 11 1 1 1",
               bus.WB_Data, bus.WB_Rd, bus.WB_Valid, bus.WB_Reg_W);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.WB_Data !== 8'h22 || bus.WB_Rd !== 3'd6) begin
      errors++;
      $display("FAIL swp_ld_after: got D=%h Rd=%0d, expected 22 6", bus.WB_Data, bus.WB_Rd);
    end
  endtask

  task automatic test_swap_upstream_change();
    preload(8'h20, 8'h11);
    preload(8'h30, 8'h99);
    drive(1'b1, 2'b11, 8'h20, 8'h22, 3'd2, 1'b0);
    tick();
    drive(1'b0, 2'b01, 8'h30, 8'h77, 3'd7, 1'b1);
    checks++;
    if (bus.Mem_W_En !== 1'b1 || bus.Mem_Address !== 8'h20 || bus.Mem_Data_in !== 8'h22) begin
      errors++;
      $display("FAIL swp_ignore_ex_bus: got W=%b A=%h D=%h, expected 1 20 22",
               bus.Mem_W_En, bus.Mem_Address, bus.Mem_Data_in);
    end
    tick();
    checks++;
    if (mem[8'h20] !== 8'h22 || mem[8'h30] !== 8'h99) begin
      errors++;
      $display("FAIL swp_ignore_ex_mem: got m20=%h m30=%h, expected 22 99", mem[8'h20], mem[8'h30]);
    end
    checks++;
    if (bus.WB_Data !== 8'h11 || bus.WB_Rd !== 3'd2 || bus.WB_Reg_W !== 1'b0 || bus.WB_Valid !== 1'b1) begin
      errors++;
      $display("FAIL swp_ignore_ex_wb: got D=%h Rd=%0d RW=%b V=%b, expected 11 2 0 1",
               bus.WB_Data, bus.WB_Rd, bus.WB_Reg_W, bus.WB_Valid);
    end
  endtask

  task automatic test_reset_mid_swap();
    preload(8'h20, 8'h11);
    drive(1'b1, 2'b11, 8'h20, 8'h22, 3'd1, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.Mem_W_En !== 1'b0 || bus.Mem_Stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_swp_bus: got W=%b S=%b, expected 0 0", bus.Mem_W_En, bus.Mem_Stall);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (mem[8'h20] !== 8'h11 || bus.WB_Valid !== 1'b0 || bus.WB_Data !== 8'h00) begin
      errors++;
      $display("FAIL rst_swp_state: got m20=%h V=%b D=%h, expected 11 0 00",
               mem[8'h20], bus.WB_Valid, bus.WB_Data);
    end
    // An IDLE stage answers a load with a read, not the abandoned swap write
    drive(1'b1, 2'b01, 8'h20, 8'h00, 3'd4, 1'b1);
    checks++;
    if (bus.Mem_R_En !== 1'b1 || bus.Mem_W_En !== 1'b0 || bus.Mem_Address !== 8'h20) begin
      errors++;
      $display("FAIL rst_swp_idle: got R=%b W=%b A=%h, expected 1 0 20",
               bus.Mem_R_En, bus.Mem_W_En, bus.Mem_Address);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++;
    if (bus.WB_Data !== 8'h11 || bus.WB_Rd !== 3'd4 || bus.WB_Valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_swp_ld: got D=%h Rd=%0d V=%b, expected 11 4 1",
               bus.WB_Data, bus.WB_Rd, bus.WB_Valid);
    end
  endtask

  task automatic test_back_to_back();
    preload(8'h40, 8'h01);
    preload(8'h41, 8'hE7);
    drive(1'b1, 2'b11, 8'h40, 8'h02, 3'd3, 1'b1);
    tick();
    // Upstream is still presenting the second swap while the first writes
    drive(1'b1, 2'b11, 8'h41, 8'h03, 3'd5, 1'b1);
    checks++;
    if (bus.Mem_Stall !== 1'b0 || bus.Mem_W_En !== 1'b1 || bus.Mem_Address !== 8'h40) begin
      errors++;
      $display("FAIL b2b_wr1: got S=%b W=%b A=%h, expected 0 1 40",
               bus.Mem_Stall, bus.Mem_W_En, bus.Mem_Address);
    end
    tick();
    checks++;
    if (bus.Mem_Stall !== 1'b1 || bus.Mem_R_En !== 1'b1 || bus.Mem_Address !== 8'h41 ||
        bus.WB_Data !== 8'h01 || bus.WB_Rd !== 3'd3) begin
      errors++;
      $display("FAIL b2b_rd2: got S=%b R=%b A=%h D=%h Rd=%0d, expected 1 1 41 01 3",
               bus.Mem_Stall, bus.Mem_R_En, bus.Mem_Address, bus.WB_Data, bus.WB_Rd);
    end
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    checks++;
    if (bus.WB_Data !== 8'hE7 || bus.WB_Rd !== 3'd5 || mem[8'h40] !== 8'h02 || mem[8'h41] !== 8'h03) begin
      errors++;
      $display("FAIL b2b_result: got D=%h Rd=%0d m40=%h m41=%h, expected e7 5 02 03",
               bus.WB_Data, bus.WB_Rd, mem[8'h40], mem[8'h41]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pre_en = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    test_reset();
    test_store_load();
    test_passthrough();
    test_swap();
    test_swap_upstream_change();
    test_reset_mid_swap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MEM) pipeline stage of the 8-bit pipelined RISC core. It sits between the EX/MEM pipeline register and the 256-byte data memory. It drives the memory's address, data, and read/write enables, and registers the stage result into the MEM/WB pipeline register. It also implements a two-cycle atomic swap (SWP), using a small state machine and a one-cycle stall to upstream.

## Interface
Parameters:
- None. Widths are fixed: 8-bit data/address, 3-bit register index.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge
- RST  in  1  reset, synchronous, active-high
- EX_Valid  in  1  EX/MEM register holds a valid instruction
- EX_Op  in  2  00 = ALU/pass-through, 01 = LD, 10 = ST, 11 = SWP
- EX_Result  in  8  ALU result; memory address for LD/ST/SWP
- EX_Data  in  8  store data for ST/SWP
- EX_Rd  in  3  destination register index
- EX_Reg_W  in  1  instruction writes a register
- Mem_Stall  out  1  upstream must hold EX/MEM this cycle
- Mem_Address  out  8  to data memory Address
- Mem_Data_in  out  8  to data memory Data_in
- Mem_W_En  out  1  to data memory W_En (memory writes on CLK edge)
- Mem_R_En  out  1  to data memory R_En
- Mem_Data_out  in  8  from data memory; asynchronous read, 0 when R_En is low
- WB_Valid  out  1  MEM/WB holds a valid instruction
- WB_Data  out  8  value to write back
- WB_Rd  out  3  writeback register index
- WB_Reg_W  out  1  writeback enable, always 0 when WB_Valid is 0

## Operation
State machine: IDLE, SWP_WR. Internal latches: Swap_Addr, Swap_Data, Swap_Old (8 bits each), Swap_Rd (3 bits), Swap_RegW (1 bit).

IDLE with EX_Valid=1:
- Op 00: no memory enables.
  - Next edge: WB_Data=EX_Result, WB_Rd=EX_Rd, WB_Reg_W=EX_Reg_W, WB_Valid=1.
- Op 01 (LD): Mem_R_En=1, Mem_Address=EX_Result.
  - Next edge: WB_Data=Mem_Data_out, WB_Reg_W=EX_Reg_W, WB_Valid=1.
- Op 10 (ST): Mem_W_En=1, Mem_Address=EX_Result, Mem_Data_in=EX_Data.
  - Next edge: WB_Valid=1, WB_Reg_W=0, WB_Data=EX_Data.
- Op 11 (SWP): Mem_R_En=1, Mem_Address=EX_Result, Mem_Stall=1.
  - Next edge: latch Swap_Old=Mem_Data_out, plus address, data, Rd and RegW. WB_Valid=0, WB_Reg_W=0 (bubble). Go to SWP_WR.

IDLE with EX_Valid=0:
- No enables.
- Next edge: WB_Valid=0, WB_Reg_W=0. WB_Data and WB_Rd hold their values.

SWP_WR:
- Mem_W_En=1, Mem_Address=Swap_Addr, Mem_Data_in=Swap_Data, Mem_R_En=0, Mem_Stall=0.
- EX_* inputs are ignored in this state, including EX_Valid.
- Next edge: WB_Data=Swap_Old, WB_Rd=Swap_Rd, WB_Reg_W=Swap_RegW, WB_Valid=1. Return to IDLE.

Combinational rules:
- Mem_Stall=1 only in IDLE with EX_Valid=1, EX_Op=11 and RST=0.
- Mem_Address and Mem_Data_in are 0 when no enable is asserted.

## Timing
- Reset (RST high at an edge):
  - State=IDLE.
  - WB_Valid=0, WB_Data=0x00, WB_Rd=0, WB_Reg_W=0.
  - All Swap_* latches = 0.
- While RST=1: Mem_W_En=0, Mem_R_En=0, Mem_Stall=0, regardless of state or inputs.
- Latency:
  - Op 00, LD, ST: 1 cycle (result visible in MEM/WB after the next edge).
  - SWP: 2 cycles, with exactly 1 stall cycle.
- Reset during SWP_WR: the write is suppressed (memory unchanged) and the state returns to IDLE.
- ST followed immediately by LD to the same address: the LD returns the stored value, because the memory write completes at the ST edge.
- A SWP immediately following a SWP is accepted in the IDLE cycle after SWP_WR. Maximum throughput is one SWP per 2 cycles.
- Addresses wrap naturally within 8 bits; no range checking is performed.

## Test plan
- Reset: hold RST=1 for 2 cycles with EX_Valid=1, EX_Op=10.
  - Required: Mem_W_En=0, Mem_R_En=0, Mem_Stall=0, WB_Valid=0, WB_Data=0x00.
- Store then load: ST data 0x5A to 0x10, then LD 0x10 with Rd=3, Reg_W=1.
  - After the ST edge: WB_Reg_W=0.
  - After the LD edge: WB_Data=0x5A, WB_Rd=3, WB_Reg_W=1.
- Pass-through: Op 00, EX_Result=0x7F, Rd=5, Reg_W=1.
  - Required: no memory enables; WB_Data=0x7F, WB_Rd=5, WB_Valid=1.
- Swap: memory[0x20]=0x11; SWP addr 0x20, data 0x22, Rd=1.
  - Cycle 1: Mem_Stall=1, Mem_R_En=1. After edge: WB_Valid=0.
  - Cycle 2: Mem_W_En=1, Mem_Data_in=0x22. After edge: WB_Data=0x11, WB_Rd=1.
  - Subsequent LD 0x20 returns 0x22.
- SWP with upstream change: in SWP_WR, drive EX_Valid=0 and EX_Result=0x30.
  - Required: the write still goes to 0x20 with 0x22; memory[0x30] is unchanged.
- Reset mid-SWP: assert RST during SWP_WR.
  - Required: Mem_W_En=0, memory[0x20] keeps 0x11, state=IDLE, WB_Valid=0.
